// File: rtl/dram_arb.sv
// dram_arb: two-master arbiter in front of the single DRAM access port.
// Master 0 is the CPU data side and master 1 is the host loader / debug
// path. Each grant carries one access. The arbiter captures the winning
// request, drives the DRAM port for one cycle and, for reads, returns the
// DRAM data with a one-cycle valid pulse to the owner.
//
// Optional feature: define DRAM_ARB_RR_EN to get round-robin tie breaking.
// If the macro is undefined, master 0 has fixed priority and master 1 can
// starve while master 0 keeps requesting.
module dram_arb #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,

  input  logic            m0_req_i,
  input  logic            m0_we_i,
  input  logic [XLEN-1:0] m0_addr_i,
  input  logic [XLEN-1:0] m0_wr_data_i,
  input  logic [3:0]      m0_byte_en_i,
  output logic            m0_gnt_o,
  output logic [XLEN-1:0] m0_rd_data_o,
  output logic            m0_rd_vld_o,

  input  logic            m1_req_i,
  input  logic            m1_we_i,
  input  logic [XLEN-1:0] m1_addr_i,
  input  logic [XLEN-1:0] m1_wr_data_i,
  input  logic [3:0]      m1_byte_en_i,
  output logic            m1_gnt_o,
  output logic [XLEN-1:0] m1_rd_data_o,
  output logic            m1_rd_vld_o,

  output logic [XLEN-1:0] dram_rd_addr_o,
  output logic [XLEN-1:0] dram_wr_addr_o,
  output logic [XLEN-1:0] dram_wr_data_o,
  output logic [3:0]      dram_wr_byte_en_o,
  input  logic [XLEN-1:0] dram_rd_data_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t          r_state;

  // Owner of the access in flight: 0 = master 0, 1 = master 1.
  logic            r_owner;

  // Request fields captured at the grant edge. The requester may change its
  // inputs from the cycle after the grant, so the DRAM port is driven from
  // these registers only.
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wr_data;
  logic [3:0]      r_byte_en;

  // One-cycle handshake pulses back to the masters.
  logic            r_gnt0;
  logic            r_gnt1;
  logic            r_vld0;
  logic            r_vld1;

`ifdef DRAM_ARB_RR_EN
  // Last master to be granted. Resets to 1 so master 0 wins the first tie.
  logic            r_last_owner;
`endif

  // Winner of the current arbitration and its request fields.
  logic            w_any_req;
  logic            w_pick;
  logic            w_sel_we;
  logic [XLEN-1:0] w_sel_addr;
  logic [XLEN-1:0] w_sel_wr_data;
  logic [3:0]      w_sel_byte_en;
  logic            w_resp;
  logic            w_write_cycle;

  // Pick the winning master among the requests present this cycle and mux its fields
  always_comb begin
    w_any_req = m0_req_i | m1_req_i;
    w_pick    = 1'b0;
`ifdef DRAM_ARB_RR_EN
    if (m0_req_i && m1_req_i) begin
      w_pick = ~r_last_owner;
    end else begin
      w_pick = m1_req_i;
    end
`else
    w_pick = m1_req_i & ~m0_req_i;
`endif
    w_sel_we      = w_pick ? m1_we_i      : m0_we_i;
    w_sel_addr    = w_pick ? m1_addr_i    : m0_addr_i;
    w_sel_wr_data = w_pick ? m1_wr_data_i : m0_wr_data_i;
    w_sel_byte_en = w_pick ? m1_byte_en_i : m0_byte_en_i;
  end

  // Access sequencer: IDLE arbitrates, ACCESS drives the port, RESP returns read data
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wr_data    <= '0;
      r_byte_en    <= 4'h0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_vld0       <= 1'b0;
      r_vld1       <= 1'b0;
`ifdef DRAM_ARB_RR_EN
      r_last_owner <= 1'b1;
`endif
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_vld0 <= 1'b0;
      r_vld1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state      <= S_ACCESS;
            r_owner      <= w_pick;
            r_we         <= w_sel_we;
            r_addr       <= w_sel_addr;
            r_wr_data    <= w_sel_wr_data;
            r_byte_en    <= w_sel_byte_en;
            r_gnt0       <= ~w_pick;
            r_gnt1       <= w_pick;
`ifdef DRAM_ARB_RR_EN
            r_last_owner <= w_pick;
`endif
          end
        end
        S_ACCESS: begin
          if (r_we) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_RESP;
            r_vld0  <= ~r_owner;
            r_vld1  <= r_owner;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // A write is only issued during ACCESS; at all other times byte enables are zero.
  assign w_write_cycle = (r_state == S_ACCESS) && r_we;
  assign w_resp        = (r_state == S_RESP);

  // The DRAM address/data lines hold the last captured request between accesses.
  assign dram_rd_addr_o    = r_addr;
  assign dram_wr_addr_o    = r_addr;
  assign dram_wr_data_o    = r_wr_data;
  assign dram_wr_byte_en_o = w_write_cycle ? r_byte_en : 4'h0;

  assign m0_gnt_o    = r_gnt0;
  assign m1_gnt_o    = r_gnt1;
  assign m0_rd_vld_o = r_vld0;
  assign m1_rd_vld_o = r_vld1;

  // Both masters see the DRAM read data during the response cycle. Outside
  // that cycle the data is forced to zero, so it reads as zero in reset.
  assign m0_rd_data_o = w_resp ? dram_rd_data_i : '0;
  assign m1_rd_data_o = w_resp ? dram_rd_data_i : '0;

endmodule

// File: tb/tb_dram_arb.sv
// tb_dram_arb: self-checking bench for dram_arb.
// A behavioural DRAM (registered read, byte-enable write) sits on the port.
// Table vectors cover the write/read/merge/zero-byte-enable cases. Read
// results are predicted into a scoreboard queue and popped when rd_vld fires.
// Hand-written sequences cover back-to-back grants, tie arbitration and
// reset during an access.
module tb_dram_arb;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;

  logic [1:0]       req = '0;
  logic [1:0]       we = '0;
  logic [1:0][31:0] addr = '0;
  logic [1:0][31:0] wdata = '0;
  logic [1:0][3:0]  be = '0;
  logic [1:0]       gnt;
  logic [1:0][31:0] rdata;
  logic [1:0]       vld;

  logic [31:0]      dramRdAddr;
  logic [31:0]      dramWrAddr;
  logic [31:0]      dramWrData;
  logic [3:0]       dramBe;
  logic [31:0]      dramRdData = '0;

  int               nCompared = 0;
  int               nMismatched = 0;
  int               cycle = 0;

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          m;
    logic [31:0] data;
  } exp_t;

  exp_t             sbq[$];
  vec_t             vecs[10];

  logic [31:0]      mem [1024] = '{default: 32'h0};

  dram_arb #(.XLEN(32)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .m0_req_i         (req[0]),
    .m0_we_i          (we[0]),
    .m0_addr_i        (addr[0]),
    .m0_wr_data_i     (wdata[0]),
    .m0_byte_en_i     (be[0]),
    .m0_gnt_o         (gnt[0]),
    .m0_rd_data_o     (rdata[0]),
    .m0_rd_vld_o      (vld[0]),
    .m1_req_i         (req[1]),
    .m1_we_i          (we[1]),
    .m1_addr_i        (addr[1]),
    .m1_wr_data_i     (wdata[1]),
    .m1_byte_en_i     (be[1]),
    .m1_gnt_o         (gnt[1]),
    .m1_rd_data_o     (rdata[1]),
    .m1_rd_vld_o      (vld[1]),
    .dram_rd_addr_o   (dramRdAddr),
    .dram_wr_addr_o   (dramWrAddr),
    .dram_wr_data_o   (dramWrData),
    .dram_wr_byte_en_o(dramBe),
    .dram_rd_data_i   (dramRdData)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used to measure grant spacing
  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural DRAM: byte-enable write and one-cycle registered read
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (dramBe[b]) mem[dramWrAddr[11:2]][8*b +: 8] <= dramWrData[8*b +: 8];
    end
    dramRdData <= mem[dramRdAddr[11:2]];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every rd_vld pulse must match the oldest predicted read
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (vld[i]) begin
          if (sbq.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL unexpected rd_vld on m%0d: got 1, expected 0", i);
          end else begin
            e = sbq.pop_front();
            checkOutput("rd_vld owner", i, e.m);
            checkOutput("rd_data", rdata[i], e.data);
          end
        end
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " m0_gnt"}, gnt[0], 0);
    checkOutput({tag, " m1_gnt"}, gnt[1], 0);
    checkOutput({tag, " m0_rd_vld"}, vld[0], 0);
    checkOutput({tag, " m1_rd_vld"}, vld[1], 0);
    checkOutput({tag, " m0_rd_data"}, rdata[0], 0);
    checkOutput({tag, " m1_rd_data"}, rdata[1], 0);
    checkOutput({tag, " dram_rd_addr"}, dramRdAddr, 0);
    checkOutput({tag, " dram_wr_addr"}, dramWrAddr, 0);
    checkOutput({tag, " dram_wr_data"}, dramWrData, 0);
    checkOutput({tag, " dram_wr_byte_en"}, dramBe, 0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One access from one master: drive at a negedge in IDLE, check the grant cycle and the response
  task automatic applyStimulus(input vec_t v);
    int   waitCyc;
    int   o;
    exp_t e;
    o = 1 - v.m;
    we[v.m]    = v.we;
    addr[v.m]  = v.addr;
    wdata[v.m] = v.data;
    be[v.m]    = v.be;
    req[v.m]   = 1'b1;
    waitCyc = 0;
    do begin
      @(negedge clk);
      waitCyc++;
    end while (!gnt[v.m] && waitCyc < 8);
    checkOutput("gnt latency", waitCyc, 1);
    if (!gnt[v.m]) begin
      req[v.m] = 1'b0;
      return;
    end
    checkOutput("other gnt", gnt[o], 0);
    checkOutput("dram_rd_addr", dramRdAddr, v.addr);
    checkOutput("dram_wr_addr", dramWrAddr, v.addr);
    checkOutput("dram_wr_byte_en", dramBe, v.we ? v.be : 4'h0);
    if (v.we) begin
      checkOutput("dram_wr_data", dramWrData, v.data);
    end else begin
      e.m = v.m;
      e.data = v.exp;
      sbq.push_back(e);
    end
    req[v.m]   = 1'b0;
    we[v.m]    = 1'($urandom);
    addr[v.m]  = $urandom;
    wdata[v.m] = $urandom;
    be[v.m]    = 4'($urandom);
    @(negedge clk);
    checkOutput("byte_en after access", dramBe, 0);
    checkOutput("gnt pulse width", gnt[v.m], 0);
    if (!v.we) begin
      checkOutput("rd_vld latency", vld[v.m], 1);
      checkOutput("other rd_vld", vld[o], 0);
      @(negedge clk);
      checkOutput("rd_vld pulse width", vld[v.m], 0);
    end
  endtask

  // Master 0 holds req through two grants; measure the grant spacing
  task automatic backToBack(input logic isWrite, input int expGap, input logic [31:0] a,
                            input logic [31:0] expData);
    int   g;
    int   budget;
    int   t[2];
    exp_t e;
    we[0]    = isWrite;
    addr[0]  = a;
    wdata[0] = 32'h5A5A_0F0F;
    be[0]    = 4'hF;
    req[0]   = 1'b1;
    g = 0;
    budget = 0;
    t[0] = 0;
    t[1] = 0;
    while (g < 2 && budget < 20) begin
      @(negedge clk);
      budget++;
      if (gnt[0]) begin
        t[g] = cycle;
        if (!isWrite) begin
          e.m = 0;
          e.data = expData;
          sbq.push_back(e);
        end
        g++;
        if (g == 2) req[0] = 1'b0;
      end
    end
    req[0] = 1'b0;
    checkOutput("back-to-back grant count", g, 2);
    if (g == 2) checkOutput("back-to-back gap", t[1] - t[0], expGap);
    repeat (3) @(negedge clk);
  endtask

  // Both masters hold req; record who wins the next four grants
  task automatic tieArbitration();
    int order[4];
    int expOrder[4];
    int g;
    int budget;
`ifdef DRAM_ARB_RR_EN
    expOrder = '{0, 1, 0, 1};
`else
    expOrder = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 2; i++) begin
      we[i]    = 1'b1;
      addr[i]  = 32'h300 + 32'(i * 4);
      wdata[i] = 32'hFFFF_FFFF;
      be[i]    = 4'h0;
    end
    req = 2'b11;
    g = 0;
    budget = 0;
    while (g < 4 && budget < 40) begin
      @(negedge clk);
      budget++;
      if (gnt != 2'b00) begin
        checkOutput("gnt one-hot", gnt, gnt[1] ? 2'b10 : 2'b01);
        order[g] = gnt[1] ? 1 : 0;
        g++;
        if (g == 4) req = 2'b00;
      end
    end
    req = 2'b00;
    checkOutput("tie grant count", g, 4);
    for (int i = 0; i < g; i++) checkOutput($sformatf("tie grant %0d owner", i), order[i], expOrder[i]);
    @(negedge clk);
  endtask

  // Reset asserted in the ACCESS cycle of a read
  task automatic resetMidRead();
    int waitCyc;
    we[0]   = 1'b0;
    addr[0] = 32'h100;
    req[0]  = 1'b1;
    waitCyc = 0;
    do begin
      @(negedge clk);
      waitCyc++;
    end while (!gnt[0] && waitCyc < 8);
    checkOutput("mid-read gnt seen", gnt[0], 1);
    rst_n  = 1'b0;
    req[0] = 1'b0;
    #1;
    checkAllZero("async reset");
    @(negedge clk);
    checkOutput("reset held rd_vld", vld[0], 0);
    checkOutput("reset held byte_en", dramBe, 0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post-reset rd_vld", vld[0], 0);
      checkOutput("post-reset gnt", gnt, 0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0] = '{0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1] = '{0, 1'b0, 32'h100, 32'h0,        4'h0, 32'hDEADBEEF};
    vecs[2] = '{1, 1'b1, 32'h100, 32'h11223344, 4'h3, 32'h0};
    vecs[3] = '{1, 1'b0, 32'h100, 32'h0,        4'h0, 32'hDEAD3344};
    vecs[4] = '{0, 1'b1, 32'h100, 32'hCAFEF00D, 4'h0, 32'h0};
    vecs[5] = '{0, 1'b0, 32'h100, 32'h0,        4'h0, 32'hDEAD3344};
    vecs[6] = '{1, 1'b1, 32'h104, 32'hA5A5A5A5, 4'hC, 32'h0};
    vecs[7] = '{1, 1'b0, 32'h104, 32'h0,        4'h0, 32'hA5A50000};
    vecs[8] = '{0, 1'b1, 32'h104, 32'h000000FF, 4'h1, 32'h0};
    vecs[9] = '{0, 1'b0, 32'h104, 32'h0,        4'h0, 32'hA5A500FF};

    @(negedge clk);
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    backToBack(1'b1, 2, 32'h200, 32'h0);
    backToBack(1'b0, 3, 32'h100, 32'hDEAD3344);

    doReset();
    tieArbitration();

    resetMidRead();
    applyStimulus(vecs[5]);

    repeat (2) @(negedge clk);
    checkOutput("scoreboard drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
